// File: rtl/max_reduce_tree_if.sv
// Beat/result bundle for max_reduce_tree.
//   master : beat source (drives in_*), observes busy/run_max/out_*
//   slave  : the reduction engine
// in_valid/in_first/in_last/in_data : one beat of NUM_IN signed lanes
// busy, run_max                     : live status of the open frame
// out_valid/out_max/out_lane/out_beat/beat_ovf : completed-frame result
interface max_reduce_tree_if #(
   parameter int DATA_WIDTH = 18,
   parameter int NUM_IN     = 64,
   parameter int BEAT_WIDTH = 13
);
   localparam int LANE_W = $clog2(NUM_IN);

   logic                         in_valid;
   logic                         in_first;
   logic                         in_last;
   logic [NUM_IN*DATA_WIDTH-1:0] in_data;
   logic                         busy;
   logic [DATA_WIDTH-1:0]        run_max;
   logic                         out_valid;
   logic [DATA_WIDTH-1:0]        out_max;
   logic [LANE_W-1:0]            out_lane;
   logic [BEAT_WIDTH-1:0]        out_beat;
   logic                         beat_ovf;

   modport master (
      output in_valid, in_first, in_last, in_data,
      input  busy, run_max, out_valid, out_max, out_lane, out_beat, beat_ovf
   );

   modport slave (
      input  in_valid, in_first, in_last, in_data,
      output busy, run_max, out_valid, out_max, out_lane, out_beat, beat_ovf
   );
endinterface

// File: rtl/max_reduce_tree.sv
// Pipelined max-reduction of NUM_IN score lanes per beat, folded into a
// per-frame maximum. Negative lanes count as 0; ties go to the lower lane
// and to the earlier beat.
// Ports: clk, rst_n (async, active-low), bus (max_reduce_tree_if.slave).
// Optional: define MAX_TREE_ARGMAX_EN to track the winning lane and beat;
// without it out_lane/out_beat are tied to 0 and no index logic exists.
//
// state  | meaning
// S_IDLE | no open frame; blocks without first are dropped, run_max held 0
// S_ACCUM| frame open; each block folded into best, beat counter advancing
module max_reduce_tree #(
   parameter int DATA_WIDTH       = 18,
   parameter int NUM_IN           = 64,
   parameter int LEVELS_PER_STAGE = 3,
   parameter int BEAT_WIDTH       = 13
) (
   input logic               clk,
   input logic               rst_n,
   max_reduce_tree_if.slave  bus
);
   localparam int LEVELS = $clog2(NUM_IN);
   localparam int STAGES = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
   localparam int LANE_W = LEVELS;
   // Level k nodes live at [2N - 2(N>>k), 2N - (N>>k)); the root is last.
   localparam int NODES  = 2*NUM_IN - 1;

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   logic [DATA_WIDTH-1:0] node_val [NODES];
`ifdef MAX_TREE_ARGMAX_EN
   logic [LANE_W-1:0]     node_lane [NODES];
`endif

   for (genvar i = 0; i < NUM_IN; i++) begin : g_leaf
      logic [DATA_WIDTH-1:0] raw;
      assign raw         = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign node_val[i] = raw[DATA_WIDTH-1] ? '0 : raw;
`ifdef MAX_TREE_ARGMAX_EN
      assign node_lane[i] = LANE_W'(i);
`endif
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int  SRC    = 2*NUM_IN - 2*(NUM_IN >> (k-1));
      localparam int  DST    = 2*NUM_IN - 2*(NUM_IN >> k);
      localparam int  CNT    = NUM_IN >> k;
      localparam bit  IS_REG = ((k % LEVELS_PER_STAGE) == 0) || (k == LEVELS);
      for (genvar j = 0; j < CNT; j++) begin : g_node
         logic                  take_b;
         logic [DATA_WIDTH-1:0] win_val;
         // Values are clamped non-negative, so an unsigned compare is exact.
         // Strict > keeps the lower lane (a) on a tie.
         assign take_b  = node_val[SRC+2*j+1] > node_val[SRC+2*j];
         assign win_val = take_b ? node_val[SRC+2*j+1] : node_val[SRC+2*j];
`ifdef MAX_TREE_ARGMAX_EN
         logic [LANE_W-1:0] win_lane;
         assign win_lane = take_b ? node_lane[SRC+2*j+1] : node_lane[SRC+2*j];
`endif
         if (IS_REG) begin : g_reg
            logic [DATA_WIDTH-1:0] val_q;
            always_ff @(posedge clk) val_q <= win_val;
            assign node_val[DST+j] = val_q;
`ifdef MAX_TREE_ARGMAX_EN
            logic [LANE_W-1:0] lane_q;
            always_ff @(posedge clk) lane_q <= win_lane;
            assign node_lane[DST+j] = lane_q;
`endif
         end else begin : g_comb
            assign node_val[DST+j] = win_val;
`ifdef MAX_TREE_ARGMAX_EN
            assign node_lane[DST+j] = win_lane;
`endif
         end
      end
   end

   // Beat markers ride alongside the tree registers; data regs need no reset
   // because nothing downstream looks at them without a valid bit.
   logic [STAGES-1:0] pipe_v, pipe_f, pipe_l;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         pipe_f <= '0;
         pipe_l <= '0;
      end else begin
         pipe_v[0] <= bus.in_valid;
         pipe_f[0] <= bus.in_valid & bus.in_first;
         pipe_l[0] <= bus.in_valid & bus.in_last;
         for (int s = 1; s < STAGES; s++) begin
            pipe_v[s] <= pipe_v[s-1];
            pipe_f[s] <= pipe_f[s-1];
            pipe_l[s] <= pipe_l[s-1];
         end
      end
   end

   logic                  blk_v, blk_first, blk_last;
   logic [DATA_WIDTH-1:0] blk_max;
   assign blk_v     = pipe_v[STAGES-1];
   assign blk_first = pipe_f[STAGES-1];
   assign blk_last  = pipe_l[STAGES-1];
   assign blk_max   = node_val[NODES-1];

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] best_q, best_d;
   logic [BEAT_WIDTH-1:0] cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_max_q, out_max_d;
   logic                  out_ovf_q, out_ovf_d;
   logic                  fold;
`ifdef MAX_TREE_ARGMAX_EN
   logic [LANE_W-1:0]     best_lane_q, best_lane_d, out_lane_q, out_lane_d;
   logic [BEAT_WIDTH-1:0] best_beat_q, best_beat_d, out_beat_q, out_beat_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         best_q      <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_max_q   <= '0;
         out_ovf_q   <= 1'b0;
`ifdef MAX_TREE_ARGMAX_EN
         best_lane_q <= '0;
         best_beat_q <= '0;
         out_lane_q  <= '0;
         out_beat_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         best_q      <= best_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_max_q   <= out_max_d;
         out_ovf_q   <= out_ovf_d;
`ifdef MAX_TREE_ARGMAX_EN
         best_lane_q <= best_lane_d;
         best_beat_q <= best_beat_d;
         out_lane_q  <= out_lane_d;
         out_beat_q  <= out_beat_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      best_d      = best_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      out_max_d   = out_max_q;
      out_ovf_d   = out_ovf_q;
      fold        = 1'b0;
`ifdef MAX_TREE_ARGMAX_EN
      best_lane_d = best_lane_q;
      best_beat_d = best_beat_q;
      out_lane_d  = out_lane_q;
      out_beat_d  = out_beat_q;
`endif
      if (blk_v && blk_first) begin
         // A first block always opens a fresh frame, abandoning any open one.
         fold    = 1'b1;
         state_d = S_ACCUM;
         best_d  = blk_max;
         cnt_d   = '0;
         ovf_d   = 1'b0;
`ifdef MAX_TREE_ARGMAX_EN
         best_lane_d = node_lane[NODES-1];
         best_beat_d = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE:  best_d = '0;
            S_ACCUM: begin
               if (blk_v) begin
                  fold = 1'b1;
                  if (cnt_q == '1) ovf_d = 1'b1;
                  else             cnt_d = cnt_q + 1'b1;
                  if (blk_max > best_q) begin
                     best_d = blk_max;
`ifdef MAX_TREE_ARGMAX_EN
                     best_lane_d = node_lane[NODES-1];
                     best_beat_d = cnt_d;
`endif
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (fold && blk_last) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b1;
         out_max_d   = best_d;
         out_ovf_d   = ovf_d;
`ifdef MAX_TREE_ARGMAX_EN
         out_lane_d  = best_lane_d;
         out_beat_d  = best_beat_d;
`endif
      end
   end

   assign bus.busy      = (state_q == S_ACCUM) | (|pipe_v);
   assign bus.run_max   = best_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_max   = out_max_q;
   assign bus.beat_ovf  = out_ovf_q;
`ifdef MAX_TREE_ARGMAX_EN
   assign bus.out_lane  = out_lane_q;
   assign bus.out_beat  = out_beat_q;
`else
   assign bus.out_lane  = '0;
   assign bus.out_beat  = '0;
`endif
endmodule

// File: doc/max_reduce_tree.md
Name: max_reduce_tree

Overview:
- Parametrised, pipelined max-reduction engine for Smith-Waterman score tracking.
- Reduces NUM_IN signed score lanes per beat through a registered comparator tree, then folds beats into a running frame maximum.
- Reports frame max, winning lane and winning beat at frame end.
- Sits after PE array (NUM_IN = PE_Array_size), feeding result/traceback control.

Parameters:
DATA_WIDTH, 18, score width incl. sign bit (two's complement)
NUM_IN, 64, lanes per beat; power of two, >= 2
LEVELS_PER_STAGE, 3, 2-input comparator levels between pipeline registers; >= 1
BEAT_WIDTH, 13, beat counter width within a frame

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  beat valid; no backpressure
in_first  input  1  beat is first of frame (qualified by in_valid)
in_last  input  1  beat is last of frame (qualified by in_valid)
in_data  input  NUM_IN*DATA_WIDTH  lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
busy  output  1  frame open or beats in flight
run_max  output  DATA_WIDTH  running max of current frame
out_valid  output  1  one-cycle pulse: frame result updated
out_max  output  DATA_WIDTH  frame maximum
out_lane  output  clog2(NUM_IN)  lane of frame maximum
out_beat  output  BEAT_WIDTH  beat index (0-based) of frame maximum
beat_ovf  output  1  beat counter saturated in reported frame

Behaviour:
- Reset: all outputs 0; FSM IDLE; all pipeline valid bits cleared. Reset mid-frame discards everything in flight; no out_valid.
- Lane value: negative lanes (MSB=1) treated as 0. Outputs never negative.
- Compare: 2-input node selects larger; tie -> lower lane index.
- Tree: L = ceil(ceil(log2 NUM_IN)/LEVELS_PER_STAGE) register stages. Defaults: 6 levels, L=2. valid/first/last travel alongside data.
- Block result visible at cycle t+L for beat accepted at edge t.
- Accumulator stage updates on edge after block result valid. run_max reflects beat t at t+L+1.
- FSM IDLE / ACCUM:
  - IDLE + blk_first: best <= blk, beat_cnt <= 0, best_beat <= 0, ovf <= 0 -> ACCUM.
  - IDLE + block without first: dropped.
  - ACCUM + non-first block: beat_cnt++ (saturates at all-ones, sets ovf). Replace best only if blk_max strictly greater (tie keeps earlier beat).
  - ACCUM + blk_first: previous frame abandoned, no out_valid; restart as from IDLE.
  - blk_last, including first+last same beat: after fold, latch out_max/out_lane/out_beat/beat_ovf. out_valid=1 for exactly one cycle; -> IDLE.
  - out_* held until next completed frame.
- in_valid=0 bubbles allowed anywhere; they never alter state.
- busy = (FSM==ACCUM) | any pipeline valid bit.
- run_max cleared to 0 in IDLE after out_valid cycle.
- Fully pipelined: one beat per cycle sustained, back-to-back frames with no gap.

Optional Feature:
- Macro MAX_TREE_ARGMAX_EN.
- Defined: lane indices carried through tree; out_lane/out_beat driven as above.
- Undefined: no index registers or beat-index tracking logic. out_lane and out_beat tied to 0.
- beat_cnt still kept for beat_ovf. Max values and timing identical.

Test Plan:
- Single-beat frame (first=last=1), lane 37 = 500, others 10 -> out_valid at t+L+1 (t+3 default); out_max=500, out_lane=37, out_beat=0.
- 4-beat frame; beat 2 lane 5 = 900; beat 3 lane 60 = 900 -> out_max=900, out_lane=5, out_beat=2 (tie keeps earlier).
- All lanes negative (0x3FFFF) for one frame -> out_max=0, out_lane=0.
- Two frames back-to-back with bubbles inside first frame -> two out_valid pulses with correct per-frame results. Second frame not polluted by first's max.
- in_first mid-frame, then rst_n low while second frame is in flight -> no out_valid for either frame; all outputs 0; busy=0.
- BEAT_WIDTH=3, 10-beat frame, max on beat 9 -> out_beat=7 (saturated), beat_ovf=1. Next frame clears beat_ovf.
